// File: rtl/lcd_bus_monitor_if.sv
// LCD write bus (E/RS/data) plus the shadow read port and status outputs of the monitor.
interface lcd_bus_monitor_if;
  logic       lcd_e;
  logic       lcd_rs;
  logic [7:0] lcd_data;
  logic       rd_row;
  logic [3:0] rd_col;
  logic [7:0] rd_char;
  logic       disp_on;
  logic [6:0] addr;
  logic       busy;
  logic       frame_pulse;
  logic       err_busy;
  logic       err_init;

  modport master (
    output lcd_e, lcd_rs, lcd_data, rd_row, rd_col,
    input  rd_char, disp_on, addr, busy, frame_pulse, err_busy, err_init
  );

  modport slave (
    input  lcd_e, lcd_rs, lcd_data, rd_row, rd_col,
    output rd_char, disp_on, addr, busy, frame_pulse, err_busy, err_init
  );
endinterface

// File: rtl/lcd_bus_monitor.sv
// Responder for an HD44780-style 8-bit write bus: decodes commands and data on E falling edges,
// keeps a 2x16 shadow DDRAM, emulates controller busy time and flags protocol violations.
module lcd_bus_monitor #(
  parameter int CLEAR_CYC = 76500,
  parameter int CMD_CYC   = 2000
) (
  input logic          clk,
  input logic          rst,
  lcd_bus_monitor_if.slave bus
);
  localparam int CW = $clog2((CLEAR_CYC > CMD_CYC) ? CLEAR_CYC : CMD_CYC) + 1;

  typedef enum logic [1:0] {WAIT_FS, IDLE, BUSY} state_t;

  logic       s1_e_reg, s2_e_reg, s1_rs_reg, s2_rs_reg;
  logic [7:0] s1_data_reg, s2_data_reg;
  logic       fall;

  state_t     state_reg, state_next;
  logic [CW-1:0] count_reg, count_next;
  logic [6:0] addr_reg, addr_next;
  logic       id_reg, id_next;
  logic       disp_reg, disp_next;
  logic       err_busy_reg, err_busy_next;
  logic       err_init_reg, err_init_next;
  logic       frame_reg, frame_next;
  logic       exec;
  logic       wr_en;
  logic       clr_all;
  logic [4:0] wr_idx;
  logic [7:0] cell_q [32];
  logic [7:0] rd_char_reg;

  // DDRAM counter stepping with the controller's 0x27<->0x40 and 0x67<->0x00 line wrap.
  function automatic logic [6:0] step_addr(input logic [6:0] a, input logic inc);
    logic [6:0] r;
    if (inc) begin
      if (a == 7'h27)      r = 7'h40;
      else if (a == 7'h67) r = 7'h00;
      else                 r = a + 7'd1;
    end else begin
      if (a == 7'h00)      r = 7'h67;
      else if (a == 7'h40) r = 7'h27;
      else                 r = a - 7'd1;
    end
    return r;
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_e_reg    <= 1'b0;
      s2_e_reg    <= 1'b0;
      s1_rs_reg   <= 1'b0;
      s2_rs_reg   <= 1'b0;
      s1_data_reg <= 8'h00;
      s2_data_reg <= 8'h00;
    end else begin
      s1_e_reg    <= bus.lcd_e;
      s2_e_reg    <= s1_e_reg;
      s1_rs_reg   <= bus.lcd_rs;
      s2_rs_reg   <= s1_rs_reg;
      s1_data_reg <= bus.lcd_data;
      s2_data_reg <= s1_data_reg;
    end
  end

  assign fall = s2_e_reg & ~s1_e_reg;

  always_comb begin
    state_next    = state_reg;
    count_next    = count_reg;
    addr_next     = addr_reg;
    id_next       = id_reg;
    disp_next     = disp_reg;
    err_busy_next = err_busy_reg;
    err_init_next = err_init_reg;
    frame_next    = 1'b0;
    exec          = 1'b0;
    wr_en         = 1'b0;
    clr_all       = 1'b0;
    wr_idx        = {addr_reg[6], addr_reg[3:0]};

    case (state_reg)
      WAIT_FS: begin
        if (fall) begin
          if (!s2_rs_reg && s2_data_reg[7:4] == 4'b0011) state_next = IDLE;
          else                                          err_init_next = 1'b1;
        end
      end
      IDLE: exec = fall;
      BUSY: begin
        // A byte arriving while busy is flagged but still honoured, restarting the timer.
        if (fall) begin
          exec          = 1'b1;
          err_busy_next = 1'b1;
        end else if (count_reg == '0) begin
          state_next = IDLE;
        end else begin
          count_next = count_reg - 1'b1;
        end
      end
      default: state_next = WAIT_FS;
    endcase

    if (exec) begin
      state_next = BUSY;
      count_next = CW'(CMD_CYC - 1);
      if (s2_rs_reg) begin
        // Visible cells are 0x00..0x0F and 0x40..0x4F, i.e. addr[5:4] == 0.
        wr_en      = (addr_reg[5:4] == 2'b00);
        frame_next = (addr_reg == 7'h4F);
        addr_next  = step_addr(addr_reg, id_reg);
      end else if (s2_data_reg[7]) begin
        addr_next = s2_data_reg[6:0];
      end else if (s2_data_reg[6] || s2_data_reg[5] || s2_data_reg[4]) begin
        addr_next = addr_reg;
      end else if (s2_data_reg[3]) begin
        disp_next = s2_data_reg[2];
      end else if (s2_data_reg[2]) begin
        id_next = s2_data_reg[1];
      end else if (s2_data_reg[1]) begin
        addr_next = 7'h00;
      end else if (s2_data_reg[0]) begin
        clr_all    = 1'b1;
        addr_next  = 7'h00;
        id_next    = 1'b1;
        count_next = CW'(CLEAR_CYC - 1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= WAIT_FS;
      count_reg    <= '0;
      addr_reg     <= 7'h00;
      id_reg       <= 1'b1;
      disp_reg     <= 1'b0;
      err_busy_reg <= 1'b0;
      err_init_reg <= 1'b0;
      frame_reg    <= 1'b0;
    end else begin
      state_reg    <= state_next;
      count_reg    <= count_next;
      addr_reg     <= addr_next;
      id_reg       <= id_next;
      disp_reg     <= disp_next;
      err_busy_reg <= err_busy_next;
      err_init_reg <= err_init_next;
      frame_reg    <= frame_next;
    end
  end

  // Cells live in flops so reset and clear-display can refill all 32 in one cycle.
  for (genvar gi = 0; gi < 32; gi++) begin : g_cell
    logic [7:0] cell_reg;
    always_ff @(posedge clk) begin
      if (rst || clr_all)                    cell_reg <= 8'h20;
      else if (wr_en && wr_idx == 5'(gi))    cell_reg <= s2_data_reg;
    end
    assign cell_q[gi] = cell_reg;
  end

  always_ff @(posedge clk) begin
    if (rst) rd_char_reg <= 8'h00;
    else     rd_char_reg <= cell_q[{bus.rd_row, bus.rd_col}];
  end

  assign bus.rd_char     = rd_char_reg;
  assign bus.disp_on     = disp_reg;
  assign bus.addr        = addr_reg;
  assign bus.busy        = (state_reg == BUSY);
  assign bus.frame_pulse = frame_reg;
  assign bus.err_busy    = err_busy_reg;
  assign bus.err_init    = err_init_reg;
endmodule

// File: tb/tb_lcd_bus_monitor.sv
// Directed bench for lcd_bus_monitor: a behavioural LCD model predicts state, and shadow reads
// flow through a scoreboard queue matched against rd_char one cycle later.
module tb_lcd_bus_monitor;
  localparam int CLEAR_CYC = 200;
  localparam int CMD_CYC   = 40;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  lcd_bus_monitor_if bus ();

  lcd_bus_monitor #(.CLEAR_CYC(CLEAR_CYC), .CMD_CYC(CMD_CYC)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int errors = 0;
  int checks = 0;
  int fp_count = 0;
  int m_fp = 0;

  logic [7:0] m_buf [32];
  logic [6:0] m_addr;
  logic       m_id, m_disp, m_init, m_err_init, m_err_busy;

  typedef struct {
    string      tag;
    logic [7:0] exp;
  } sb_t;
  sb_t sb_q[$];

  always @(negedge clk) if (!rst && bus.frame_pulse === 1'b1) fp_count++;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    for (int i = 0; i < 32; i++) m_buf[i] = 8'h20;
    m_addr = 7'h00; m_id = 1'b1; m_disp = 1'b0;
    m_init = 1'b0; m_err_init = 1'b0; m_err_busy = 1'b0;
  endtask

  function automatic logic [6:0] m_step(input logic [6:0] a, input logic inc);
    if (inc) return (a == 7'h27) ? 7'h40 : (a == 7'h67) ? 7'h00 : a + 7'd1;
    else     return (a == 7'h00) ? 7'h67 : (a == 7'h40) ? 7'h27 : a - 7'd1;
  endfunction

  task automatic model_apply(input logic rs, input logic [7:0] d);
    if (!m_init) begin
      if (!rs && d[7:4] == 4'h3) m_init = 1'b1;
      else                       m_err_init = 1'b1;
      return;
    end
    if (rs) begin
      if (m_addr <= 7'h0F)                        m_buf[int'(m_addr)] = d;
      else if (m_addr >= 7'h40 && m_addr <= 7'h4F) m_buf[16 + int'(m_addr - 7'h40)] = d;
      if (m_addr == 7'h4F) m_fp++;
      m_addr = m_step(m_addr, m_id);
    end else begin
      casez (d)
        8'b1???????: m_addr = d[6:0];
        8'b00001???: m_disp = d[2];
        8'b000001??: m_id = d[1];
        8'b0000001?: m_addr = 7'h00;
        8'b00000001: begin
          for (int i = 0; i < 32; i++) m_buf[i] = 8'h20;
          m_addr = 7'h00; m_id = 1'b1;
        end
        default: ;
      endcase
    end
  endtask

  task automatic send_raw(input logic rs, input logic [7:0] d);
    model_apply(rs, d);
    bus.lcd_rs = rs; bus.lcd_data = d; bus.lcd_e = 1'b1;
    repeat (4) tick();
    bus.lcd_e = 1'b0;
    repeat (4) tick();
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while (bus.busy === 1'b1 && n < CLEAR_CYC + 50) begin tick(); n++; end
    chk({tag, "_idle"}, 32'(bus.busy), 32'd0);
  endtask

  task automatic send(input logic rs, input logic [7:0] d);
    send_raw(rs, d);
    wait_idle($sformatf("send_%0d_%02h", rs, d));
  endtask

  task automatic send_str(input string s);
    for (int i = 0; i < s.len(); i++) send(1'b1, s[i]);
  endtask

  task automatic check_rows(input string tag);
    sb_t e;
    for (int i = 0; i < 32; i++) begin
      bus.rd_row = i[4];
      bus.rd_col = i[3:0];
      sb_q.push_back('{tag, m_buf[i]});
      tick();
      e = sb_q.pop_front();
      chk($sformatf("%s_cell%0d", e.tag, i), 32'(bus.rd_char), 32'(e.exp));
    end
  endtask

  task automatic check_status(input string tag);
    chk({tag, "_addr"},     32'(bus.addr),     32'(m_addr));
    chk({tag, "_disp_on"},  32'(bus.disp_on),  32'(m_disp));
    chk({tag, "_err_init"}, 32'(bus.err_init), 32'(m_err_init));
    chk({tag, "_err_busy"}, 32'(bus.err_busy), 32'(m_err_busy));
    chk({tag, "_frames"},   32'(fp_count),     32'(m_fp));
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_rd_char"},  32'(bus.rd_char),     32'd0);
    chk({tag, "_disp_on"},  32'(bus.disp_on),     32'd0);
    chk({tag, "_addr"},     32'(bus.addr),        32'd0);
    chk({tag, "_busy"},     32'(bus.busy),        32'd0);
    chk({tag, "_frame"},    32'(bus.frame_pulse), 32'd0);
    chk({tag, "_err_busy"}, 32'(bus.err_busy),    32'd0);
    chk({tag, "_err_init"}, 32'(bus.err_init),    32'd0);
  endtask

  initial begin
    int n;
    bus.lcd_e = 1'b0; bus.lcd_rs = 1'b0; bus.lcd_data = 8'h00;
    bus.rd_row = 1'b0; bus.rd_col = 4'h0;
    model_reset();
    repeat (3) tick();
    check_zero("reset");
    rst = 1'b0;
    tick();

    // Data before function set
    send(1'b1, 8'h41);
    check_status("t1");
    check_rows("t1");

    // Init sequence and top row
    send(1'b0, 8'h38); send(1'b0, 8'h08); send(1'b0, 8'h01);
    send(1'b0, 8'h06); send(1'b0, 8'h0C); send(1'b0, 8'h80);
    send_str("      DO        ");
    check_rows("t2");
    check_status("t2");
    chk("t2_addr_abs", 32'(bus.addr), 32'h10);
    chk("t2_disp_abs", 32'(bus.disp_on), 32'd1);

    // Bottom row and frame pulse
    send(1'b0, 8'hC0);
    send_str("ABCDEFGHIJKLMNOP");
    check_rows("t3");
    check_status("t3");
    chk("t3_addr_abs", 32'(bus.addr), 32'h50);
    chk("t3_one_frame", 32'(fp_count), 32'd1);

    // Second byte while clear is still busy
    send_raw(1'b0, 8'h01);
    repeat (2) tick();
    m_err_busy = 1'b1;
    send_raw(1'b0, 8'h0C);
    n = 0;
    while (bus.busy === 1'b1 && n < CLEAR_CYC + 50) begin tick(); n++; end
    chk("t4_busy_len", 32'(n), 32'(CMD_CYC - 2));
    check_status("t4");
    check_rows("t4");

    // Decrementing entry mode and wrap below 0x00
    send(1'b0, 8'h04); send(1'b0, 8'h80);
    send(1'b1, 8'h41); send(1'b1, 8'h42);
    check_rows("t5");
    check_status("t5");
    chk("t5_addr_abs", 32'(bus.addr), 32'h66);

    // Wrap 0x27 -> 0x40 with dropped write, then reset while E is high
    send(1'b0, 8'h06); send(1'b0, 8'hA7); send(1'b1, 8'h78);
    check_status("t6");
    chk("t6_addr_abs", 32'(bus.addr), 32'h40);
    check_rows("t6");
    bus.lcd_rs = 1'b1; bus.lcd_data = 8'h5A; bus.lcd_e = 1'b1;
    repeat (3) tick();
    rst = 1'b1;
    repeat (2) tick();
    check_zero("t6_rst");
    bus.lcd_e = 1'b0;
    repeat (2) tick();
    rst = 1'b0;
    model_reset();
    m_fp = fp_count;
    tick();
    check_rows("t6_after_rst");
    check_status("t6_after_rst");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
